// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 program-counter sequencer.
package lc3_ctrl_pkg;

    typedef enum logic [3:0] {
        HALTED,
        F1,
        F2,
        F3,
        DEC,
        BR,
        JMP,
        JSR1,
        JSR2,
        EXEC,
        PAUSE1,
        PAUSE2
    } state_t;

    // Opcodes (IR[15:12]) that change control flow or stall the sequencer
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    // PC select mux encodings; PCSEL_ZERO is the reset vector and never issued here
    localparam logic [1:0] PCSEL_INC   = 2'd0;
    localparam logic [1:0] PCSEL_ADDER = 2'd1;
    localparam logic [1:0] PCSEL_BUS   = 2'd2;
    localparam logic [1:0] PCSEL_ZERO  = 2'd3;

    // Branch is taken when any requested condition matches a set condition code
    function automatic logic br_taken(input logic [2:0] cond, input logic [2:0] nzp);
        return |(cond & nzp);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for the memory-read phase of fetch. done is high on the last
// cycle of a MEM_WAIT-cycle window that starts when enable first rises after clear.
module mem_wait_timer #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [3:0] count;

    // Count read cycles; clear has priority so every window starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    assign done = (count == 4'(MEM_WAIT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// LC-3 program-counter sequencer: fetch, decode and PC-changing instructions.
// Outputs are decoded from the current state (plus IR/NZP for branch and JSR
// target selection). Optional feature: define PC_SEQ_BREAKPOINT_EN to add the
// BP_ADDR/PC_IN breakpoint ports, which divert F1 into PAUSE1 on a PC match.
module pc_sequencer
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic [2:0]  NZP,
`ifdef PC_SEQ_BREAKPOINT_EN
    input  logic [15:0] BP_ADDR,
    input  logic [15:0] PC_IN,
`endif
    output logic        LD_PC,
    output logic [1:0]  PCMUX,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_REG,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        MIO_EN,
    output logic        Halted
);

    state_t     state;
    logic       wait_done;
    logic [3:0] opcode;
    logic       bp_hit;
    logic       unused_ir;

    assign opcode    = IR[15:12];
    assign unused_ir = ^IR[8:0];

`ifdef PC_SEQ_BREAKPOINT_EN
    logic bp_skip;
    assign bp_hit = (PC_IN == BP_ADDR) && !bp_skip;
`else
    assign bp_hit = 1'b0;
`endif

    mem_wait_timer #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk    (Clk),
        .rst    (Reset),
        .clear  (state != F2),
        .enable (state == F2),
        .done   (wait_done)
    );

    // Next-state sequencing; the breakpoint skip flag lives alongside the state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= HALTED;
`ifdef PC_SEQ_BREAKPOINT_EN
            bp_skip <= 1'b0;
`endif
        end else begin
            case (state)
                HALTED: if (Run) state <= F1;
                F1: begin
                    if (bp_hit) begin
                        state <= PAUSE1;
                    end else begin
                        state <= F2;
`ifdef PC_SEQ_BREAKPOINT_EN
                        bp_skip <= 1'b0;
`endif
                    end
                end
                F2: if (wait_done) state <= F3;
                F3: state <= DEC;
                DEC: begin
                    case (opcode)
                        OP_BR:    state <= BR;
                        OP_JMP:   state <= JMP;
                        OP_JSR:   state <= JSR1;
                        OP_PAUSE: state <= PAUSE1;
                        default:  state <= EXEC;
                    endcase
                end
                BR:     state <= F1;
                JMP:    state <= F1;
                JSR1:   state <= JSR2;
                JSR2:   state <= F1;
                EXEC:   state <= F1;
                PAUSE1: if (Continue) state <= PAUSE2;
                PAUSE2: begin
                    if (!Continue) begin
                        state <= F1;
`ifdef PC_SEQ_BREAKPOINT_EN
                        bp_skip <= 1'b1;
`endif
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

    // Control-word decode of the current state
    always_comb begin
        LD_PC   = 1'b0;
        PCMUX   = PCSEL_INC;
        LD_MAR  = 1'b0;
        LD_MDR  = 1'b0;
        LD_IR   = 1'b0;
        LD_REG  = 1'b0;
        GatePC  = 1'b0;
        GateMDR = 1'b0;
        MIO_EN  = 1'b0;
        Halted  = 1'b0;
        case (state)
            HALTED: Halted = 1'b1;
            F1: begin
                // A breakpoint hit suppresses the whole fetch so PC stays put
                if (!bp_hit) begin
                    GatePC = 1'b1;
                    LD_MAR = 1'b1;
                    LD_PC  = 1'b1;
                    PCMUX  = PCSEL_INC;
                end
            end
            F2: begin
                MIO_EN = 1'b1;
                LD_MDR = 1'b1;
            end
            F3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            BR: begin
                if (br_taken(IR[11:9], NZP)) begin
                    LD_PC = 1'b1;
                    PCMUX = PCSEL_ADDER;
                end
            end
            JMP: begin
                LD_PC = 1'b1;
                PCMUX = PCSEL_BUS;
            end
            JSR1: begin
                GatePC = 1'b1;
                LD_REG = 1'b1;
            end
            JSR2: begin
                LD_PC = 1'b1;
                PCMUX = IR[11] ? PCSEL_ADDER : PCSEL_BUS;
            end
            EXEC: LD_REG = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of instructions with expected per-cycle control
// words pushed to a scoreboard queue, plus hand-written reset/pause sequences.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic [2:0]  NZP;
`ifdef PC_SEQ_BREAKPOINT_EN
    logic [15:0] BP_ADDR;
    logic [15:0] PC_IN;
`endif
    logic        LD_PC;
    logic [1:0]  PCMUX;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        LD_IR;
    logic        LD_REG;
    logic        GatePC;
    logic        GateMDR;
    logic        MIO_EN;
    logic        Halted;

    pc_sequencer #(.MEM_WAIT(2)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Continue (Continue),
        .IR       (IR),
        .NZP      (NZP),
`ifdef PC_SEQ_BREAKPOINT_EN
        .BP_ADDR  (BP_ADDR),
        .PC_IN    (PC_IN),
`endif
        .LD_PC    (LD_PC),
        .PCMUX    (PCMUX),
        .LD_MAR   (LD_MAR),
        .LD_MDR   (LD_MDR),
        .LD_IR    (LD_IR),
        .LD_REG   (LD_REG),
        .GatePC   (GatePC),
        .GateMDR  (GateMDR),
        .MIO_EN   (MIO_EN),
        .Halted   (Halted)
    );

    always #5 Clk = ~Clk;

    // Control word: {LD_PC, PCMUX[1:0], LD_MAR, LD_MDR, LD_IR, LD_REG, GatePC, GateMDR, MIO_EN, Halted}
    logic [10:0] act;
    assign act = {LD_PC, PCMUX, LD_MAR, LD_MDR, LD_IR, LD_REG, GatePC, GateMDR, MIO_EN, Halted};

    localparam logic [10:0] E_HALT  = 11'b00000000001;
    localparam logic [10:0] E_F1    = 11'b10010001000;
    localparam logic [10:0] E_F2    = 11'b00001000010;
    localparam logic [10:0] E_F3    = 11'b00000100100;
    localparam logic [10:0] E_ZERO  = 11'b00000000000;
    localparam logic [10:0] E_EXEC  = 11'b00000010000;
    localparam logic [10:0] E_BRT   = 11'b10100000000;
    localparam logic [10:0] E_PCBUS = 11'b11000000000;
    localparam logic [10:0] E_JSR1  = 11'b00000011000;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  nzp;
        int          ntail;
        logic [10:0] t0;
        logic [10:0] t1;
        string       nm;
    } vec_t;

    vec_t        vecs[9];
    logic [10:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic push(input logic [10:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Compare the current cycle against the oldest expectation, then advance one cycle
    task automatic step_check();
        logic [10:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, e);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) step_check();
    endtask

    // Fetch phase expectations shared by every instruction loop
    task automatic push_fetch(input string nm);
        push(E_F1, {nm, "_f1"});
        push(E_F2, {nm, "_f2a"});
        push(E_F2, {nm, "_f2b"});
        push(E_F3, {nm, "_f3"});
        push(E_ZERO, {nm, "_dec"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h1042, 3'b000, 1, E_EXEC,  E_ZERO, "add"};
        vecs[1] = '{16'h0402, 3'b010, 1, E_BRT,   E_ZERO, "brz_taken"};
        vecs[2] = '{16'h0402, 3'b100, 1, E_ZERO,  E_ZERO, "brz_not_taken"};
        vecs[3] = '{16'h0000, 3'b111, 1, E_ZERO,  E_ZERO, "br_nzp000"};
        vecs[4] = '{16'h0E00, 3'b001, 1, E_BRT,   E_ZERO, "brnzp_p"};
        vecs[5] = '{16'h4805, 3'b000, 2, E_JSR1,  E_BRT,  "jsr"};
        vecs[6] = '{16'h4080, 3'b000, 2, E_JSR1,  E_PCBUS, "jsrr"};
        vecs[7] = '{16'hC1C0, 3'b000, 1, E_PCBUS, E_ZERO, "jmp"};
        vecs[8] = '{16'h5020, 3'b111, 1, E_EXEC,  E_ZERO, "and"};

        Reset    = 1'b1;
        Run      = 1'b0;
        Continue = 1'b0;
        IR       = 16'h0000;
        NZP      = 3'b000;
`ifdef PC_SEQ_BREAKPOINT_EN
        BP_ADDR  = 16'hFFFF;
        PC_IN    = 16'h0000;
`endif
        #1;
        push(E_HALT, "reset_held");
        push(E_HALT, "reset_held");
        drain();

        Reset = 1'b0;
        push(E_HALT, "halted_idle");
        push(E_HALT, "halted_idle");
        drain();

        Run = 1'b1;
        push(E_HALT, "run_sampled");
        drain();

        // Instruction table: each loop F1,F2,F2,F3,DEC,tail then back to F1
        for (int i = 0; i < 9; i++) begin
            IR  = vecs[i].ir;
            NZP = vecs[i].nzp;
            push_fetch(vecs[i].nm);
            push(vecs[i].t0, {vecs[i].nm, "_t0"});
            if (vecs[i].ntail == 2) push(vecs[i].t1, {vecs[i].nm, "_t1"});
            drain();
        end

        // PAUSE: stays put with Continue low, one release per press
        IR = 16'hD000;
        push_fetch("pause");
        for (int i = 0; i < 10; i++) push(E_ZERO, "pause1_hold");
        drain();
        Continue = 1'b1;
        for (int i = 0; i < 6; i++) push(E_ZERO, "pause_continue_high");
        drain();
        Continue = 1'b0;
        IR = 16'h1042;
        push(E_ZERO, "pause2_release");
        push_fetch("after_pause");
        push(E_EXEC, "after_pause_exec");
        drain();

        // Reset in the middle of the memory wait
        push(E_F1, "midwait_f1");
        push(E_F2, "midwait_f2a");
        drain();
        Reset = 1'b1;
        #1;
        push(E_HALT, "async_reset");
        push(E_HALT, "reset_hold");
        drain();
        Reset = 1'b0;
        push(E_HALT, "restart_halted");
        push_fetch("restart");
        push(E_EXEC, "restart_exec");
        drain();

`ifdef PC_SEQ_BREAKPOINT_EN
        // Breakpoint at current PC: F1 fetch is suppressed, then skipped once after release
        BP_ADDR = 16'h3003;
        PC_IN   = 16'h3003;
        push(E_ZERO, "bp_f1_suppressed");
        push(E_ZERO, "bp_pause1");
        drain();
        Continue = 1'b1;
        push(E_ZERO, "bp_pause1_cont");
        push(E_ZERO, "bp_pause2");
        drain();
        Continue = 1'b0;
        push(E_ZERO, "bp_pause2_release");
        push(E_F1, "bp_skip_f1");
        drain();
        PC_IN = 16'h3004;
        push(E_F2, "bp_f2a");
        push(E_F2, "bp_f2b");
        push(E_F3, "bp_f3");
        push(E_ZERO, "bp_dec");
        push(E_EXEC, "bp_exec");
        push(E_F1, "bp_next_f1");
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
